// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the reset sequencer.
//   seq_state_e  : sequencer phases (hold, peripheral release, grace, run)
//   TripWDefault : default width of the watchdog trip counter
//   max_u        : elaboration-time helper for counter sizing
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    StHold,
    StPeriph,
    StGrace,
    StRun
  } seq_state_e;

  localparam int unsigned TripWDefault = 8;

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Reset sequencer signal bundle.
//   Requests/config (into the sequencer): ext_reset_n, wdresetn_in, vblank, wd_enable, trip_clr
//   Reset outputs: periph_reset_n, cpu_reset_n
//   Watchdog control: wdis_n, wdog_clr_n
//   Diagnostics: trip_count, trip_flag, busy
// master = the sequencer itself, slave = the surrounding core / host.
interface reset_sequencer_if
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned TRIP_W = TripWDefault
);

  logic              ext_reset_n;
  logic              wdresetn_in;
  logic              vblank;
  logic              wd_enable;
  logic              trip_clr;
  logic              periph_reset_n;
  logic              cpu_reset_n;
  logic              wdis_n;
  logic              wdog_clr_n;
  logic [TRIP_W-1:0] trip_count;
  logic              trip_flag;
  logic              busy;

  modport master (
    input  ext_reset_n,
    input  wdresetn_in,
    input  vblank,
    input  wd_enable,
    input  trip_clr,
    output periph_reset_n,
    output cpu_reset_n,
    output wdis_n,
    output wdog_clr_n,
    output trip_count,
    output trip_flag,
    output busy
  );

  modport slave (
    output ext_reset_n,
    output wdresetn_in,
    output vblank,
    output wd_enable,
    output trip_clr,
    input  periph_reset_n,
    input  cpu_reset_n,
    input  wdis_n,
    input  wdog_clr_n,
    input  trip_count,
    input  trip_flag,
    input  busy
  );

endinterface

// File: rtl/reset_sequencer_reset_sync.sv
// Two-flop synchroniser for an asynchronous active-low level.
// Both flops clear to 1 so the synchronised output reads "not requested" while in reset.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low clear (forces output to 1)
//   d_i    : asynchronous input
//   q_o    : synchronised output, two clk_i cycles of latency
module reset_sequencer_reset_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_sequencer.sv
// Central reset controller: merges host reset and watchdog trips into a staged release
// (peripherals first, CPU STAGGER_CYCLES later), holds the watchdog frozen for GRACE_FRAMES
// vblanks after CPU release, and keeps a saturating trip counter plus sticky trip flag.
//   clk, reset_n : system clock, asynchronous active-low reset
//   bus          : reset_sequencer_if master modport (requests in, resets/watchdog/diag out)
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned GRACE_FRAMES   = 4,
  parameter int unsigned TRIP_W         = TripWDefault
) (
  input logic               clk,
  input logic               reset_n,
  reset_sequencer_if.master bus
);

  localparam int unsigned TimerW = $clog2(max_u(HOLD_CYCLES, STAGGER_CYCLES) + 1);
  localparam int unsigned FrameW = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;

  localparam logic [TimerW-1:0] HoldLast    = TimerW'(HOLD_CYCLES - 1);
  localparam logic [TimerW-1:0] StaggerLast = TimerW'(STAGGER_CYCLES - 1);
  localparam logic [FrameW-1:0] FrameLast   = FrameW'(GRACE_FRAMES - 1);

  seq_state_e        state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [FrameW-1:0] frames_q, frames_d;

  logic wd_prev_q;
  logic vblank_q;

  logic              periph_q, periph_d;
  logic              cpu_q, cpu_d;
  logic              wdis_q, wdis_d;
  logic              wdog_clr_q, wdog_clr_d;
  logic              busy_q, busy_d;
  logic [TRIP_W-1:0] trip_count_q, trip_count_d;
  logic              trip_flag_q, trip_flag_d;

  logic ext_sync;
  logic trip;
  logic vb_rise;
  logic req;

  reset_sequencer_reset_sync u_ext_sync (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (bus.ext_reset_n),
    .q_o    (ext_sync)
  );

  // Watchdog source is edge-only: a held-low wdresetn_in must not extend HOLD.
  assign trip    = wd_prev_q & ~bus.wdresetn_in;
  assign vb_rise = bus.vblank & ~vblank_q;
  assign req     = ~ext_sync | trip;

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    frames_d   = frames_q;
    wdog_clr_d = 1'b1;

    if (req) begin
      state_d = StHold;
      timer_d = '0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (timer_q == HoldLast) begin
            state_d    = StPeriph;
            timer_d    = '0;
            wdog_clr_d = 1'b0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        StPeriph: begin
          if (timer_q == StaggerLast) begin
            state_d = StGrace;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TimerW'(1);
          end
        end
        StGrace: begin
          if (GRACE_FRAMES == 0) begin
            state_d = StRun;
          end else if (vb_rise) begin
            if (frames_q == FrameLast) begin
              state_d = StRun;
            end else begin
              frames_d = frames_q + FrameW'(1);
            end
          end
        end
        StRun: begin
          state_d = StRun;
        end
        default: begin
          state_d = StHold;
          timer_d = '0;
        end
      endcase
    end

    // Frame count only has meaning inside GRACE; start every GRACE from zero.
    if (state_d != StGrace) begin
      frames_d = '0;
    end
  end

  // Registered outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    periph_d = (state_d != StHold);
    cpu_d    = (state_d == StGrace) || (state_d == StRun);
    busy_d   = (state_d != StRun);
    unique case (state_d)
      StHold:  wdis_d = 1'b1;  // never freeze the watchdog mid-trip
      StRun:   wdis_d = bus.wd_enable;
      default: wdis_d = 1'b0;
    endcase
  end

  // Trip accounting runs in every state; a trip beats a coincident clear.
  always_comb begin
    trip_count_d = trip_count_q;
    trip_flag_d  = trip_flag_q;
    if (trip) begin
      trip_flag_d = 1'b1;
      if (trip_count_q != '1) begin
        trip_count_d = trip_count_q + TRIP_W'(1);
      end
    end else if (bus.trip_clr) begin
      trip_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StHold;
      timer_q      <= '0;
      frames_q     <= '0;
      wd_prev_q    <= 1'b1;
      vblank_q     <= 1'b0;
      periph_q     <= 1'b0;
      cpu_q        <= 1'b0;
      wdis_q       <= 1'b0;
      wdog_clr_q   <= 1'b1;
      busy_q       <= 1'b1;
      trip_count_q <= '0;
      trip_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      frames_q     <= frames_d;
      wd_prev_q    <= bus.wdresetn_in;
      vblank_q     <= bus.vblank;
      periph_q     <= periph_d;
      cpu_q        <= cpu_d;
      wdis_q       <= wdis_d;
      wdog_clr_q   <= wdog_clr_d;
      busy_q       <= busy_d;
      trip_count_q <= trip_count_d;
      trip_flag_q  <= trip_flag_d;
    end
  end

  assign bus.periph_reset_n = periph_q;
  assign bus.cpu_reset_n    = cpu_q;
  assign bus.wdis_n         = wdis_q;
  assign bus.wdog_clr_n     = wdog_clr_q;
  assign bus.busy           = busy_q;
  assign bus.trip_count     = trip_count_q;
  assign bus.trip_flag      = trip_flag_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Central reset controller for the arcade core. Merges the external/host reset and the watchdog trip into staged reset releases: peripherals first, then the CPU.
- Drives the watchdog's disable input during a post-reset grace period and clears the watchdog count on each reset exit.
- Keeps a saturating trip counter for diagnostics (OSD/debug readout).

Parameters:
- HOLD_CYCLES, 16, minimum clk cycles all resets stay asserted after the last reset request.
- STAGGER_CYCLES, 8, clk cycles between periph_reset_n release and cpu_reset_n release.
- GRACE_FRAMES, 4, VBLANK rising edges after CPU release during which the watchdog is held disabled.
- TRIP_W, 8, trip counter width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- ext_reset_n  in  1  host/button reset request, asynchronous, active-low. Double-flop synchronised internally.
- wdresetn_in  in  1  watchdog reset output, clk domain, active-low.
- vblank  in  1  video VBLANK, clk domain.
- wd_enable  in  1  config bit: 1 = watchdog permitted in RUN.
- trip_clr  in  1  one-cycle pulse, clears trip_flag.
- periph_reset_n  out  1  reset to video/sound/IO, active-low.
- cpu_reset_n  out  1  reset to CPU, active-low.
- wdis_n  out  1  to watchdog WDISn. 0 = watchdog counting frozen.
- wdog_clr_n  out  1  one-cycle active-low pulse, ANDed externally with the CPU WDOGn strobe.
- trip_count  out  TRIP_W  saturating count of watchdog trips.
- trip_flag  out  1  sticky, set by a trip, cleared by trip_clr.
- busy  out  1  high in every state except RUN.

Behaviour:
- Reset (reset_n=0), asynchronous:
  - State=HOLD, timer=0.
  - periph_reset_n=0, cpu_reset_n=0, wdis_n=0, wdog_clr_n=1.
  - trip_count=0, trip_flag=0, busy=1.
  - Both sync flops and the wdresetn_in edge register are set to 1.
- Reset request (req), in all states:
  - req = (synchronised ext_reset_n == 0) OR (falling edge of wdresetn_in: previous sample 1, current 0).
  - The watchdog source is edge-triggered only. A low level of wdresetn_in never re-triggers or extends HOLD.
- All outputs are registered. Any req forces next state HOLD and timer=0, with both resets low on the following cycle (1-cycle latency from the edge-detect or sync output).
- HOLD:
  - Resets low, wdis_n=1 so the watchdog is not frozen mid-trip.
  - timer increments each cycle without req.
  - When timer==HOLD_CYCLES-1 and there is no req: wdog_clr_n=0 for exactly that transition cycle (registered, visible one cycle), timer=0, go PERIPH.
- PERIPH:
  - periph_reset_n=1, cpu_reset_n=0, wdis_n=0.
  - After STAGGER_CYCLES cycles, go GRACE.
- GRACE:
  - Both resets=1, wdis_n=0.
  - Frame counter counts VBLANK rising edges, using an internal vblank delay flop.
  - At the GRACE_FRAMES-th edge, go RUN.
  - If GRACE_FRAMES=0, go RUN the cycle after entry.
- RUN:
  - Both resets=1, wdis_n=wd_enable (registered, 1-cycle lag on wd_enable changes), busy=0.
- Trip accounting:
  - A wdresetn_in falling edge increments trip_count, saturating at all-ones, and sets trip_flag. This applies in every state.
  - trip_clr clears trip_flag only.
  - Simultaneous trip and trip_clr: the trip wins (flag=1).
  - trip_count is cleared only by reset_n.
- ext_reset_n held low indefinitely: remain in HOLD, timer pinned at 0.
- ext_reset_n released mid-HOLD: the full HOLD_CYCLES count restarts from its release.
- Counter widths: timer = $clog2(max(HOLD_CYCLES, STAGGER_CYCLES)+1). The frame counter is sized for GRACE_FRAMES.

Decomposition:
- Shared package: state enum (HOLD, PERIPH, GRACE, RUN) and a TRIP_W default constant.
- Natural sub-module: reset_sync (2-flop synchroniser with asynchronous clear to 1), reusable for other asynchronous inputs.
- The edge detectors and counters stay inline.

Test Plan:
1. Power-up, defaults, ext_reset_n=1:
   - periph_reset_n rises about 16 cycles after reset_n release.
   - cpu_reset_n rises 8 cycles later.
   - wdog_clr_n pulses low once at HOLD exit.
   - After 4 vblank rising edges, wdis_n=1 and busy=0.
2. In RUN, drive wdresetn_in 1→0 and hold it low for 100 cycles:
   - Both resets go low the next cycle.
   - trip_count=1, trip_flag=1.
   - Sequence re-runs normally despite the sustained low level.
3. ext_reset_n low for 50 cycles during GRACE:
   - Resets stay low throughout.
   - Release occurs after 2 sync cycles + 16 HOLD cycles.
   - trip_count unchanged.
4. 260 watchdog trips:
   - trip_count saturates at 255.
   - trip_clr coincident with trip 261 leaves trip_flag=1.
   - A later isolated trip_clr gives trip_flag=0.
5. wd_enable=0 in RUN: wdis_n=0 one cycle later. Set wd_enable=1: wdis_n=1 one cycle later.
6. reset_n asserted mid-PERIPH:
   - All outputs return to reset values immediately (asynchronously).
   - trip_count=0.
